sm83_bus_target: RTL and testbench

- Responder end of the SM83 external memory bus.
- Tracks the CPU's T1–T4 machine cycle and services the CPU's rd/wr/address/data pins, so the CPU samples valid read data on the T4 edge.
- Hosts the 127-byte HRAM (FF80–FFFE) internally.
- Forwards every other access to a downstream memory port with a req/ack handshake, returning open-bus 0xFF when no ack arrives in time.

---
 rtl/sm83_bus_pkg.sv | 35 +++
 rtl/sm83_hram.sv | 29 ++
 rtl/sm83_bus_target.sv | 198 +++++++++++++++++++
 tb/tb_sm83_bus_target.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/sm83_bus_pkg.sv
// Shared types and constants for the SM83 bus target: state encoding, HRAM window,
// open-bus value and address helpers.
package sm83_bus_pkg;

  typedef logic [7:0] byte_t;

  localparam logic [15:0] HRAM_BASE  = 16'hFF80;
  localparam logic [15:0] HRAM_LAST  = 16'hFFFE;
  localparam byte_t       OPEN_BUS   = 8'hFF;
  localparam int unsigned HRAM_DEPTH = 127;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_HRAM     = 3'd1,
    ST_EXT_WAIT = 3'd2,
    ST_EXT_DONE = 3'd3,
    ST_BLOCKED  = 3'd4
  } bus_state_e;

  // Access captured at the T1 edge and held for the rest of the machine cycle.
  typedef struct packed {
    logic [15:0] addr;
    logic        is_read;
    byte_t       wdata;
  } bus_req_t;

  function automatic logic is_hram(input logic [15:0] addr);
    return (addr >= HRAM_BASE) && (addr <= HRAM_LAST);
  endfunction

  function automatic logic [6:0] hram_offset(input logic [15:0] addr);
    return 7'(addr - HRAM_BASE);
  endfunction

endpackage

// File: rtl/sm83_hram.sv
// 127x8 high RAM: synchronous write, registered read, addressed by offset from
// HRAM_BASE. Contents are deliberately not reset.
module sm83_hram
  import sm83_bus_pkg::*;
(
  input  logic       clk,
  input  logic       we_i,
  input  logic       re_i,
  input  logic [6:0] addr_i,
  input  byte_t      wdata_i,
  output byte_t      rdata_o
);

  byte_t mem_q [HRAM_DEPTH];
  byte_t rdata_q;

  // Array write port and read-data register.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sm83_bus_target.sv
// SM83 external-bus responder: tracks T1..T4, serves HRAM locally and forwards other
// accesses downstream with timeout. SM83_BUS_DMA_LOCK_EN blocks non-HRAM access during DMA.
module sm83_bus_target
  import sm83_bus_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        t1_i,
  input  logic        t2_i,
  input  logic        t3_i,
  input  logic        t4_i,
  input  logic        cpu_rd_i,
  input  logic        cpu_wr_i,
  input  logic [15:0] cpu_addr_i,
  input  logic [7:0]  cpu_dout_i,
  output logic [7:0]  cpu_din_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [15:0] mem_addr_o,
  output logic [7:0]  mem_wdata_o,
  input  logic [7:0]  mem_rdata_i,
  input  logic        mem_ack_i,
  output logic        bus_timeout_o,
  input  logic        dma_active_i
);

  bus_state_e  state_q, state_d;
  bus_req_t    req_q, req_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  byte_t       mem_wdata_q, mem_wdata_d;
  byte_t       latch_q, latch_d;
  logic        timeout_q, timeout_d;

  logic        hram_we_s;
  logic        hram_re_s;
  logic [6:0]  hram_addr_s;
  byte_t       hram_rdata_s;
  logic        cycle_start_s;
  logic        unused_phase_s;

  // T2/T3 are implied by the state sequence; only T1 and T4 edges are decision points.
  assign unused_phase_s = t2_i ^ t3_i;
  assign cycle_start_s  = t1_i && (cpu_rd_i || cpu_wr_i);

`ifndef SM83_BUS_DMA_LOCK_EN
  logic unused_dma_s;
  assign unused_dma_s = dma_active_i;
`endif

  sm83_hram u_hram (
    .clk     (clk),
    .we_i    (hram_we_s),
    .re_i    (hram_re_s),
    .addr_i  (hram_addr_s),
    .wdata_i (cpu_dout_i),
    .rdata_o (hram_rdata_s)
  );

  // Next-state, downstream request and read-latch logic.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    timeout_d   = 1'b0;
    hram_we_s   = 1'b0;
    hram_re_s   = 1'b0;
    hram_addr_s = hram_offset(req_q.addr);
    if (t4_i) begin
      latch_d = OPEN_BUS;
    end else begin
      latch_d = latch_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (cycle_start_s) begin
          req_d.addr    = cpu_addr_i;
          req_d.is_read = cpu_rd_i;
          req_d.wdata   = cpu_dout_i;
          if (is_hram(cpu_addr_i)) begin
            state_d     = ST_HRAM;
            hram_re_s   = cpu_rd_i;
            hram_addr_s = hram_offset(cpu_addr_i);
          end
`ifdef SM83_BUS_DMA_LOCK_EN
          else if (dma_active_i) begin
            state_d = ST_BLOCKED;
          end
`endif
          else begin
            state_d     = ST_EXT_WAIT;
            mem_req_d   = 1'b1;
            mem_we_d    = !cpu_rd_i;
            mem_addr_d  = cpu_addr_i;
            mem_wdata_d = cpu_dout_i;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HRAM: begin
        if (t4_i) begin
          hram_we_s = !req_q.is_read;
          state_d   = ST_IDLE;
        end else begin
          state_d = ST_HRAM;
        end
      end
      ST_EXT_WAIT: begin
        // At T4 the cycle ends regardless; a same-cycle ack is forwarded combinationally.
        if (t4_i) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          timeout_d = !mem_ack_i;
        end else if (mem_ack_i) begin
          state_d   = ST_EXT_DONE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (req_q.is_read) begin
            latch_d = mem_rdata_i;
          end else begin
            latch_d = latch_q;
          end
        end else begin
          state_d = ST_EXT_WAIT;
        end
      end
      ST_EXT_DONE: begin
        if (t4_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_EXT_DONE;
        end
      end
`ifdef SM83_BUS_DMA_LOCK_EN
      ST_BLOCKED: begin
        if (t4_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_BLOCKED;
        end
      end
`endif
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset; HRAM contents are untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 8'h00;
      latch_q     <= OPEN_BUS;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      latch_q     <= latch_d;
      timeout_q   <= timeout_d;
    end
  end

  // HRAM read data lives in the array's read register from T2 on.
  always_comb begin
    if ((state_q == ST_HRAM) && req_q.is_read) begin
      cpu_din_o = hram_rdata_s;
    end else if ((state_q == ST_EXT_WAIT) && req_q.is_read && t4_i && mem_ack_i) begin
      cpu_din_o = mem_rdata_i;
    end else begin
      cpu_din_o = latch_q;
    end
  end

  assign mem_req_o     = mem_req_q;
  assign mem_we_o      = mem_we_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_wdata_o   = mem_wdata_q;
  assign bus_timeout_o = timeout_q;

endmodule

// File: tb/tb_sm83_bus_target.sv
// Directed bench for sm83_bus_target: HRAM, external ack timing, timeout, reset abort,
// and the SM83_BUS_DMA_LOCK_EN behaviour when that macro is defined.
module tb_sm83_bus_target;

  logic        clk;
  logic        reset;
  logic        t1, t2, t3, t4;
  logic        cpu_rd, cpu_wr;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic [7:0]  cpu_din;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic        bus_timeout;
  logic        dma_active;

  int n_vec = 0;
  int n_err = 0;

  logic        obs_req   [1:4];
  logic        obs_we    [1:4];
  logic [15:0] obs_addr  [1:4];
  logic [7:0]  obs_wdata [1:4];
  logic [7:0]  obs_din   [1:4];
  logic        obs_to_after, obs_to_next, obs_req_after;
  logic [7:0]  obs_din_after;

  sm83_bus_target dut (
    .clk          (clk),
    .reset        (reset),
    .t1_i         (t1),
    .t2_i         (t2),
    .t3_i         (t3),
    .t4_i         (t4),
    .cpu_rd_i     (cpu_rd),
    .cpu_wr_i     (cpu_wr),
    .cpu_addr_i   (cpu_addr),
    .cpu_dout_i   (cpu_dout),
    .cpu_din_o    (cpu_din),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_rdata_i  (mem_rdata),
    .mem_ack_i    (mem_ack),
    .bus_timeout_o(bus_timeout),
    .dma_active_i (dma_active)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input int ph, input logic rd, input logic wr, input logic [15:0] a,
                       input logic [7:0] d, input logic ack, input logic [7:0] rdat);
    t1 = (ph == 1); t2 = (ph == 2); t3 = (ph == 3); t4 = (ph == 4);
    cpu_rd = rd; cpu_wr = wr; cpu_addr = a; cpu_dout = d;
    mem_ack = ack; mem_rdata = rdat;
  endtask

  // One full machine cycle; ack_ph selects the T-phase carrying mem_ack (0 = none).
  task automatic bus_cycle(input logic rd, input logic wr, input logic [15:0] a,
                           input logic [7:0] d, input int ack_ph, input logic [7:0] rdat);
    for (int ph = 1; ph <= 4; ph++) begin
      drive(ph, rd, wr, a, d, ph == ack_ph, rdat);
      @(negedge clk);
      obs_req[ph]   = mem_req;
      obs_we[ph]    = mem_we;
      obs_addr[ph]  = mem_addr;
      obs_wdata[ph] = mem_wdata;
      obs_din[ph]   = cpu_din;
      @(posedge clk); #1;
    end
    drive(0, 1'b0, 1'b0, a, d, 1'b0, rdat);
    obs_to_after  = bus_timeout;
    obs_req_after = mem_req;
    obs_din_after = cpu_din;
    @(posedge clk); #1;
    obs_to_next = bus_timeout;
  endtask

  function automatic logic [15:0] req_pat();
    return {12'h000, obs_req[1], obs_req[2], obs_req[3], obs_req[4]};
  endfunction

  initial begin
    dma_active = 1'b0;
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_din", {8'h00, cpu_din}, 16'h00FF);
    check_val("rst_req", {15'h0, mem_req}, 16'h0000);
    check_val("rst_we", {15'h0, mem_we}, 16'h0000);
    check_val("rst_addr", mem_addr, 16'h0000);
    check_val("rst_wdata", {8'h00, mem_wdata}, 16'h0000);
    check_val("rst_to", {15'h0, bus_timeout}, 16'h0000);
    reset = 1'b0;
    @(posedge clk); #1;

    bus_cycle(1'b0, 1'b1, 16'hFF90, 8'h5A, 0, 8'h00);
    check_val("hw_req", req_pat(), 16'h0000);
    check_val("hw_to", {15'h0, obs_to_after}, 16'h0000);
    bus_cycle(1'b1, 1'b0, 16'hFF90, 8'h00, 0, 8'h00);
    check_val("hr_din", {8'h00, obs_din[4]}, 16'h005A);
    check_val("hr_req", req_pat(), 16'h0000);

    bus_cycle(1'b1, 1'b0, 16'hC000, 8'h00, 3, 8'h3C);
    check_val("er3_req", req_pat(), 16'h0006);
    check_val("er3_addr", obs_addr[2], 16'hC000);
    check_val("er3_we", {15'h0, obs_we[2]}, 16'h0000);
    check_val("er3_din", {8'h00, obs_din[4]}, 16'h003C);
    check_val("er3_to", {15'h0, obs_to_after}, 16'h0000);

    bus_cycle(1'b0, 1'b1, 16'h8000, 8'h77, 2, 8'h00);
    check_val("ew2_req", req_pat(), 16'h0004);
    check_val("ew2_we", {15'h0, obs_we[2]}, 16'h0001);
    check_val("ew2_addr", obs_addr[2], 16'h8000);
    check_val("ew2_wdata", {8'h00, obs_wdata[2]}, 16'h0077);
    check_val("ew2_we_t3", {15'h0, obs_we[3]}, 16'h0000);

    bus_cycle(1'b1, 1'b0, 16'hA000, 8'h00, 0, 8'h00);
    check_val("to_din", {8'h00, obs_din[4]}, 16'h00FF);
    check_val("to_req", req_pat(), 16'h0007);
    check_val("to_pulse", {15'h0, obs_to_after}, 16'h0001);
    check_val("to_pulse_end", {15'h0, obs_to_next}, 16'h0000);
    check_val("to_req_after", {15'h0, obs_req_after}, 16'h0000);

    bus_cycle(1'b1, 1'b0, 16'hB000, 8'h00, 4, 8'h96);
    check_val("er4_din", {8'h00, obs_din[4]}, 16'h0096);
    check_val("er4_din_after", {8'h00, obs_din_after}, 16'h00FF);
    check_val("er4_to", {15'h0, obs_to_after}, 16'h0000);

    bus_cycle(1'b1, 1'b0, 16'hFFFF, 8'h00, 2, 8'h12);
    check_val("ffff_req", req_pat(), 16'h0004);
    check_val("ffff_din", {8'h00, obs_din[4]}, 16'h0012);

    bus_cycle(1'b0, 1'b1, 16'hFFFE, 8'hA5, 0, 8'h00);
    bus_cycle(1'b1, 1'b0, 16'hFFFE, 8'h00, 0, 8'h00);
    check_val("fffe_din", {8'h00, obs_din[4]}, 16'h00A5);
    check_val("fffe_req", req_pat(), 16'h0000);
    bus_cycle(1'b0, 1'b1, 16'hFF80, 8'h11, 0, 8'h00);
    bus_cycle(1'b1, 1'b0, 16'hFF80, 8'h00, 0, 8'h00);
    check_val("ff80_din", {8'h00, obs_din[4]}, 16'h0011);

    bus_cycle(1'b1, 1'b1, 16'hFF90, 8'hEE, 0, 8'h00);
    check_val("rdwr_din", {8'h00, obs_din[4]}, 16'h005A);
    bus_cycle(1'b1, 1'b0, 16'hFF90, 8'h00, 0, 8'h00);
    check_val("rdwr_keep", {8'h00, obs_din[4]}, 16'h005A);

    drive(1, 1'b1, 1'b0, 16'hD000, 8'h00, 1'b0, 8'h00);
    @(posedge clk); #1;
    drive(2, 1'b1, 1'b0, 16'hD000, 8'h00, 1'b0, 8'h00);
    @(posedge clk); #1;
    drive(3, 1'b1, 1'b0, 16'hD000, 8'h00, 1'b0, 8'h00);
    reset = 1'b1;
    @(negedge clk);
    check_val("rstmid_req_t3", {15'h0, mem_req}, 16'h0001);
    @(posedge clk); #1;
    reset = 1'b0;
    drive(4, 1'b1, 1'b0, 16'hD000, 8'h00, 1'b1, 8'h55);
    @(negedge clk);
    check_val("rstmid_req", {15'h0, mem_req}, 16'h0000);
    check_val("rstmid_din", {8'h00, cpu_din}, 16'h00FF);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h00);
    check_val("rstmid_din_after", {8'h00, cpu_din}, 16'h00FF);
    check_val("rstmid_to", {15'h0, bus_timeout}, 16'h0000);
    @(posedge clk); #1;
    bus_cycle(1'b1, 1'b0, 16'hFF90, 8'h00, 0, 8'h00);
    check_val("rstmid_hram", {8'h00, obs_din[4]}, 16'h005A);

    dma_active = 1'b1;
    bus_cycle(1'b1, 1'b0, 16'hC000, 8'h00, 2, 8'h3C);
`ifdef SM83_BUS_DMA_LOCK_EN
    check_val("dma_din", {8'h00, obs_din[4]}, 16'h00FF);
    check_val("dma_req", req_pat(), 16'h0000);
    check_val("dma_to", {15'h0, obs_to_after}, 16'h0000);
`else
    check_val("nodma_din", {8'h00, obs_din[4]}, 16'h003C);
    check_val("nodma_req", req_pat(), 16'h0004);
`endif
    bus_cycle(1'b1, 1'b0, 16'hFF80, 8'h00, 0, 8'h00);
    check_val("dma_hram", {8'h00, obs_din[4]}, 16'h0011);
    dma_active = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
